// File: rtl/y86_pkg.sv
// Shared Y86-64 register-file definitions for the decode-stage scoreboard.
package y86_pkg;

  localparam logic [3:0] RAX  = 4'h0;
  localparam logic [3:0] RCX  = 4'h1;
  localparam logic [3:0] RDX  = 4'h2;
  localparam logic [3:0] RBX  = 4'h3;
  localparam logic [3:0] RSP  = 4'h4;
  localparam logic [3:0] RBP  = 4'h5;
  localparam logic [3:0] RSI  = 4'h6;
  localparam logic [3:0] RDI  = 4'h7;
  localparam logic [3:0] R8   = 4'h8;
  localparam logic [3:0] R9   = 4'h9;
  localparam logic [3:0] R10  = 4'hA;
  localparam logic [3:0] R11  = 4'hB;
  localparam logic [3:0] R12  = 4'hC;
  localparam logic [3:0] R13  = 4'hD;
  localparam logic [3:0] R14  = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int NREG_DEFAULT = 15;

endpackage

// File: rtl/sb_counter.sv
// Saturating pending-write counter for one register; reports an error pulse
// on overflow (held at max) or underflow (clamped to zero).
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       inc,
  input  logic [1:0] dec,
  output logic       nz,
  output logic       err_evt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Net change of inc minus dec applied as one step, with clamping.
  always_comb begin
    cnt_nxt_s = cnt_r;
    err_evt   = 1'b0;
    case ({inc, dec})
      3'b100: begin
        if (cnt_r == CNT_MAX) begin
          err_evt = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + ONE;
        end
      end
      3'b001, 3'b110: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          err_evt = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - ONE;
        end
      end
      3'b010, 3'b111: begin
        if (cnt_r <= ONE) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          err_evt   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - ONE - ONE;
        end
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // Counter state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign nz = |cnt_r;

endmodule

// File: rtl/rf_scoreboard.sv
// Decode hazard scoreboard: per-register pending-write counters and stall.
// Optional stall statistics counter enabled by defining RF_SB_STATS_EN.
module rf_scoreboard
  import y86_pkg::*;
#(
  parameter int NREG  = NREG_DEFAULT,
  parameter int CNT_W = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            issue_valid,
  input  logic [3:0]      issue_srcA,
  input  logic [3:0]      issue_srcB,
  input  logic [3:0]      issue_dstE,
  input  logic [3:0]      issue_dstM,
  input  logic            retire_valid,
  input  logic [3:0]      retire_dstE,
  input  logic [3:0]      retire_dstM,
  input  logic            kill_valid,
  input  logic [3:0]      kill_dstE,
  input  logic [3:0]      kill_dstM,
  input  logic            err_clr,
  output logic            stall_d,
  output logic [NREG-1:0] busy_mask,
  output logic            err,
  output logic [31:0]     stall_cycles
);

  logic [NREG-1:0] busy_s;
  logic [NREG-1:0] err_evt_s;
  logic [15:0]     busy_id_s;
  logic            err_r;

  // Widen to the full 4-bit ID space so RNONE and IDs >= NREG read as idle.
  always_comb begin
    busy_id_s = 16'h0000;
    busy_id_s[NREG-1:0] = busy_s;
  end

  assign stall_d = issue_valid & (busy_id_s[issue_srcA] | busy_id_s[issue_srcB]);

  for (genvar i = 0; i < NREG; i++) begin : g_cnt
    localparam logic [3:0] ID = 4'(i);
    logic inc_s;
    logic ret_s;
    logic kill_s;

    // dstE == dstM yields a single hit, so popq %rsp counts once.
    assign inc_s  = issue_valid & ~stall_d & ((issue_dstE == ID) | (issue_dstM == ID));
    assign ret_s  = retire_valid & ((retire_dstE == ID) | (retire_dstM == ID));
    assign kill_s = kill_valid & ((kill_dstE == ID) | (kill_dstM == ID));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .inc     (inc_s),
      .dec     ({1'b0, ret_s} + {1'b0, kill_s}),
      .nz      (busy_s[i]),
      .err_evt (err_evt_s[i])
    );
  end

  assign busy_mask = busy_s;

  // Sticky error; a new error in the same cycle beats err_clr.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else if (|err_evt_s) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;

`ifdef RF_SB_STATS_EN
  logic [31:0] stall_cycles_r;

  // Saturating count of stalled decode cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_r <= 32'h0000_0000;
    end else if (err_clr) begin
      stall_cycles_r <= 32'h0000_0000;
    end else if (stall_d && (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'h0000_0001;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign stall_cycles = stall_cycles_r;
`else
  assign stall_cycles = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: arithmetic reference model plus directed vectors.
module tb_rf_scoreboard;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid, retire_valid, kill_valid, err_clr;
  logic [3:0]  issue_srcA, issue_srcB, issue_dstE, issue_dstM;
  logic [3:0]  retire_dstE, retire_dstM, kill_dstE, kill_dstM;
  logic        stall_d, err;
  logic [14:0] busy_mask;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  int          cnt_m [15] = '{default: 0};
  bit          err_m = 1'b0;
  logic [31:0] stats_m = 32'h0;

  rf_scoreboard dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_srcA(issue_srcA), .issue_srcB(issue_srcB),
    .issue_dstE(issue_dstE), .issue_dstM(issue_dstM),
    .retire_valid(retire_valid), .retire_dstE(retire_dstE), .retire_dstM(retire_dstM),
    .kill_valid(kill_valid), .kill_dstE(kill_dstE), .kill_dstM(kill_dstM),
    .err_clr(err_clr), .stall_d(stall_d), .busy_mask(busy_mask),
    .err(err), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_stall();
    bit a, b;
    a = (issue_srcA < 4'd15) && (cnt_m[issue_srcA] != 0);
    b = (issue_srcB < 4'd15) && (cnt_m[issue_srcB] != 0);
    return issue_valid && (a || b);
  endfunction

  function automatic logic [14:0] model_busy();
    logic [14:0] m;
    for (int i = 0; i < 15; i++) m[i] = (cnt_m[i] != 0);
    return m;
  endfunction

  function automatic logic [31:0] model_stats();
`ifdef RF_SB_STATS_EN
    return stats_m;
`else
    return 32'h0;
`endif
  endfunction

  // Reference model: integer counts, net change per cycle, clamp to [0,3].
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) cnt_m[i] <= 0;
      err_m   <= 1'b0;
      stats_m <= 32'h0;
    end else begin
      bit st, e;
      int n;
      st = model_stall();
      e  = 1'b0;
      for (int i = 0; i < 15; i++) begin
        n = cnt_m[i];
        if (issue_valid && !st && (issue_dstE == i || issue_dstM == i)) n = n + 1;
        if (retire_valid && (retire_dstE == i || retire_dstM == i)) n = n - 1;
        if (kill_valid && (kill_dstE == i || kill_dstM == i)) n = n - 1;
        if (n > 3) begin n = 3; e = 1'b1; end
        else if (n < 0) begin n = 0; e = 1'b1; end
        cnt_m[i] <= n;
      end
      err_m <= e ? 1'b1 : (err_clr ? 1'b0 : err_m);
      if (err_clr) stats_m <= 32'h0;
      else if (st && stats_m != 32'hFFFF_FFFF) stats_m <= stats_m + 32'h1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    chk("stall_d", {31'h0, stall_d}, {31'h0, model_stall()});
    chk("busy_mask", {17'h0, busy_mask}, {17'h0, model_busy()});
    chk("err", {31'h0, err}, {31'h0, err_m});
    chk("stall_cycles", stall_cycles, model_stats());
  end

  task automatic set_in(input logic iv, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic rv, input logic [3:0] re, input logic [3:0] rm,
                        input logic kv, input logic [3:0] ke, input logic [3:0] km,
                        input logic ec);
    issue_valid = iv;  issue_srcA = sa;  issue_srcB = sb;
    issue_dstE = de;   issue_dstM = dm;
    retire_valid = rv; retire_dstE = re; retire_dstM = rm;
    kill_valid = kv;   kill_dstE = ke;   kill_dstM = km;
    err_clr = ec;
  endtask

  task automatic idle();
    set_in(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_d(input logic [3:0] de, input logic [3:0] dm);
    set_in(1'b1, 4'hF, 4'hF, de, dm, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0);
  endtask

  task automatic retire_d(input logic [3:0] re, input logic [3:0] rm);
    set_in(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1, re, rm, 1'b0, 4'hF, 4'hF, 1'b0);
  endtask

  initial begin
    logic [3:0] a, b;
    idle();
    repeat (2) @(posedge clock);
    #1;
    chk("reset busy", {17'h0, busy_mask}, 32'h0);
    chk("reset err", {31'h0, err}, 32'h0);
    chk("reset stall", {31'h0, stall_d}, 32'h0);
    chk("reset stats", stall_cycles, 32'h0);
    reset_n = 1'b1;
    tick();

    // 1: basic RAW hazard on rax
    issue_d(4'h0, 4'hF); tick();
    chk("t1 busy rax", {17'h0, busy_mask}, 32'h0001);
    set_in(1'b1, 4'h0, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0); #1;
    chk("t1 stall", {31'h0, stall_d}, 32'h1);
    tick();
    set_in(1'b1, 4'h0, 4'hF, 4'hF, 4'hF, 1'b1, 4'h0, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0); #1;
    chk("t1 stall same-cycle retire", {31'h0, stall_d}, 32'h1);
    tick();
    set_in(1'b1, 4'h0, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0); #1;
    chk("t1 stall cleared", {31'h0, stall_d}, 32'h0);
    chk("t1 busy cleared", {17'h0, busy_mask}, 32'h0);
    idle(); tick();

    // 2: popq %rsp counts once
    issue_d(4'h4, 4'h4); tick();
    chk("t2 busy rsp", {17'h0, busy_mask}, 32'h0010);
    retire_d(4'h4, 4'h4); tick();
    chk("t2 busy after retire", {17'h0, busy_mask}, 32'h0);
    chk("t2 err", {31'h0, err}, 32'h0);

    // 3: simultaneous inc and dec on rbx nets to zero
    issue_d(4'h3, 4'hF); tick();
    set_in(1'b1, 4'hF, 4'hF, 4'h3, 4'hF, 1'b1, 4'h3, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0); tick();
    chk("t3 busy rbx", {17'h0, busy_mask}, 32'h0008);
    retire_d(4'h3, 4'hF); tick();
    chk("t3 busy drained", {17'h0, busy_mask}, 32'h0);
    chk("t3 err", {31'h0, err}, 32'h0);

    // 4: overflow on rdx, err_clr keeps the count
    for (int k = 0; k < 3; k++) begin issue_d(4'h2, 4'hF); tick(); end
    chk("t4 no err at max", {31'h0, err}, 32'h0);
    issue_d(4'h2, 4'hF); tick();
    chk("t4 overflow err", {31'h0, err}, 32'h1);
    set_in(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b1); tick();
    chk("t4 err cleared", {31'h0, err}, 32'h0);
    chk("t4 busy rdx", {17'h0, busy_mask}, 32'h0004);
    retire_d(4'h2, 4'hF); tick();
    retire_d(4'h2, 4'hF); tick();
    chk("t4 still busy", {17'h0, busy_mask}, 32'h0004);
    retire_d(4'h2, 4'hF); tick();
    chk("t4 drained", {17'h0, busy_mask}, 32'h0);
    chk("t4 no underflow", {31'h0, err}, 32'h0);

    // 5: kill underflow, then no-source issue with every register busy
    set_in(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 4'h7, 1'b0); tick();
    chk("t5 underflow err", {31'h0, err}, 32'h1);
    chk("t5 busy zero", {17'h0, busy_mask}, 32'h0);
    set_in(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b1); tick();
    chk("t5 err cleared", {31'h0, err}, 32'h0);
    for (int k = 0; k < 8; k++) begin
      a = 4'(2 * k);
      b = (k == 7) ? 4'hF : 4'(2 * k + 1);
      issue_d(a, b); tick();
    end
    chk("t5 all busy", {17'h0, busy_mask}, 32'h7FFF);
    issue_d(4'hF, 4'hF); #1;
    chk("t5 no-src no stall", {31'h0, stall_d}, 32'h0);
    tick();
    for (int k = 0; k < 8; k++) begin
      a = 4'(2 * k);
      b = (k == 7) ? 4'hF : 4'(2 * k + 1);
      retire_d(a, b); tick();
    end
    chk("t5 all drained", {17'h0, busy_mask}, 32'h0);

    // 6: stalled issue discarded, stall statistics, async reset
    set_in(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b1); tick();
    issue_d(4'h5, 4'hF); tick();
    set_in(1'b1, 4'hF, 4'h5, 4'h9, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0);
    repeat (4) tick();
    set_in(1'b1, 4'hF, 4'h5, 4'h9, 4'hF, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 4'h8, 1'b0);
    tick();
    chk("t6 r9 not counted", {17'h0, busy_mask}, 32'h0020);
    chk("t6 err from kill", {31'h0, err}, 32'h1);
`ifdef RF_SB_STATS_EN
    chk("t6 stall_cycles", stall_cycles, 32'd5);
`else
    chk("t6 stall_cycles", stall_cycles, 32'd0);
`endif
    set_in(1'b1, 4'hF, 4'h5, 4'h9, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF, 1'b0);
    #2;
    reset_n = 1'b0;
    #2;
    chk("async rst busy", {17'h0, busy_mask}, 32'h0);
    chk("async rst err", {31'h0, err}, 32'h0);
    chk("async rst stall", {31'h0, stall_d}, 32'h0);
    chk("async rst stats", stall_cycles, 32'h0);
    idle();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
